prog_sequencer: RTL

Parametrised fetch-and-run controller for the single-cycle core. It replaces the fixed program counter, cycle counter and halt/Ack logic with one block. The block handles multi-program selection, the Start/Ack handshake, absolute and relative branching, halt detection, a saturating cycle counter and an optional watchdog timeout. It sits between the testbench/host handshake and the instruction ROM address port. Control and ALU results feed its branch inputs.

---
 rtl/prog_seq_pkg.sv | 29 ++
 rtl/prog_sequencer_pc_next.sv | 24 ++
 rtl/prog_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
// Start addresses are computed, not stored.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MAX_INST_W = 64;

    function automatic logic [31:0] start_addr(
        input int unsigned idx,
        input int unsigned pc_w,
        input int unsigned num_progs
    );
        int unsigned stride;
        stride = (32'd1 << pc_w) / num_progs;
        return idx * stride;
    endfunction

    // Callers pad narrower instructions with ones.
    function automatic logic is_halt(input logic [MAX_INST_W-1:0] instr);
        return &instr;
    endfunction

endpackage

// File: rtl/prog_sequencer_pc_next.sv
// Next-PC mux: absolute jump, taken relative branch, else increment.
// All arithmetic wraps modulo 2**PC_W.
module prog_sequencer_pc_next #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            branch_abs_i,
    input  logic            branch_rel_en_i,
    input  logic            alu_flag_i,
    output logic [PC_W-1:0] pc_next_o
);

    always_comb begin
        if (branch_abs_i) begin
            pc_next_o = target_i;
        end else if (branch_rel_en_i && alu_flag_i) begin
            pc_next_o = pc_i + target_i;
        end else begin
            pc_next_o = pc_i + PC_W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch-and-run controller: program select, Start/Ack handshake,
// branching, halt detection, saturating cycle count and watchdog.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int INST_W    = 9,
    parameter int NUM_PROGS = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 0,
    localparam int SEL_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [SEL_W-1:0]  ProgSel,
    input  logic [INST_W-1:0] Instruction,
    input  logic              BranchAbs,
    input  logic              BranchRelEn,
    input  logic              ALU_flag,
    input  logic [PC_W-1:0]   Target,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Ack,
    output logic              TimedOut,
    output logic              Running,
    output logic [CNT_W-1:0]  CycleCt
);

    state_e           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_nx;
    logic [PC_W-1:0]  load_pc;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             ack_q;
    logic             to_q;
    logic             halt;
    logic             wd_hit;
    int unsigned      sel_idx;

    prog_sequencer_pc_next #(
        .PC_W(PC_W)
    ) u_pc_next (
        .pc_i           (pc_q),
        .target_i       (Target),
        .branch_abs_i   (BranchAbs),
        .branch_rel_en_i(BranchRelEn),
        .alu_flag_i     (ALU_flag),
        .pc_next_o      (pc_nx)
    );

    always_comb begin
        sel_idx = 32'(ProgSel);
        if (sel_idx >= NUM_PROGS) begin
            sel_idx = 0;
        end
        load_pc = PC_W'(start_addr(sel_idx, PC_W, NUM_PROGS));
    end

    assign halt    = is_halt({{(MAX_INST_W-INST_W){1'b1}}, Instruction});
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // Compare the unsaturated count so a limit above the counter range never fires.
    assign wd_hit  = (TIMEOUT != 0) &&
                     ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (Start) begin
            state_q <= LOAD;
            pc_q    <= load_pc;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                LOAD: state_q <= RUN;
                RUN: begin
                    cnt_q <= cnt_inc;
                    if (halt) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end else if (wd_hit) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        to_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_nx;
                    end
                end
                IDLE, DONE: ;
            endcase
        end
    end

    assign ProgCtr  = pc_q;
    assign Ack      = ack_q;
    assign TimedOut = to_q;
    assign CycleCt  = cnt_q;
    assign Running  = (state_q == RUN);

endmodule
